// File: rtl/sa_cache_pkg.sv
// Shared types for the set-associative cache miss sequencer: FSM states,
// default field widths and the address split into tag/index/offset.
package sa_cache_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int TAG_W_DEF    = 18;
  localparam int INDEX_W_DEF  = 8;
  localparam int OFFSET_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FETCH,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]    tag;
    logic [INDEX_W_DEF-1:0]  index;
    logic [OFFSET_W_DEF-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W_DEF-1:0] addr);
    addr_fields_t f;
    f.tag    = addr[ADDR_W_DEF-1 -: TAG_W_DEF];
    f.index  = addr[OFFSET_W_DEF +: INDEX_W_DEF];
    f.offset = addr[OFFSET_W_DEF-1:0];
    return f;
  endfunction

endpackage

// File: rtl/sa_cache_timeout_cnt.sv
// Memory handshake watchdog: counts enabled cycles since the last clear and
// raises term once LIMIT is reached (the count then holds).
module sa_cache_timeout_cnt #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !term) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign term = (count_reg == CNT_W'(LIMIT));

endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// Miss sequencer between a CPU port, the sa_cache datapath and backing memory.
// Optional SA_CACHE_PERF_CNT_EN adds saturating hit/miss/evict counters.
module sa_cache_miss_ctrl
  import sa_cache_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int INDEX_W     = INDEX_W_DEF,
  parameter int OFFSET_W    = OFFSET_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic                cpu_req_we,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_resp_data,
  output logic                cpu_resp_err,
  output logic [TAG_W-1:0]    c_tag,
  output logic [INDEX_W-1:0]  c_index,
  output logic [OFFSET_W-1:0] c_offset,
  output logic [DATA_W-1:0]   c_dataW,
  output logic                c_memRW,
  output logic [DATA_W-1:0]   c_mem_line,
  output logic                c_mem_response,
  input  logic [DATA_W-1:0]   c_data,
  input  logic                c_miss,
  input  logic                c_evict,
  input  logic [DATA_W-1:0]   c_evict_data,
  input  logic [ADDR_W-1:0]   c_evict_addr,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
`ifdef SA_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hits,
  output logic [31:0]         perf_misses,
  output logic [31:0]         perf_evicts
`endif
);

  localparam int TMO_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

  state_t             state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               we_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               replay_reg;
  logic               mem_rw_reg;
  logic [DATA_W-1:0]  mem_line_reg;
  logic               mem_response_reg;
  logic               req_valid_reg;
  logic               req_we_reg;
  logic [ADDR_W-1:0]  req_addr_reg;
  logic [DATA_W-1:0]  req_wdata_reg;
  logic               resp_valid_reg;
  logic               resp_err_reg;
  logic [DATA_W-1:0]  resp_data_reg;

  addr_fields_t       fields;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               tmo_clr;
  logic               tmo_en;
  logic               tmo_term;
  logic               mem_progress;

  assign fields     = split_addr(addr_reg);
  assign fetch_addr = {fields.tag, fields.index, {OFFSET_W{1'b0}}};

  // The watchdog restarts whenever a new memory phase begins.
  assign tmo_clr = (state_reg == LOOKUP) ||
                   ((state_reg == WB || state_reg == FETCH) && mem_req_ready);
  assign tmo_en  = (state_reg == WB) || (state_reg == FETCH) || (state_reg == WAIT);
  assign mem_progress = ((state_reg == WB || state_reg == FETCH) && mem_req_ready) ||
                        ((state_reg == WAIT) && (mem_response_reg || mem_resp_valid));

  sa_cache_timeout_cnt #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (TMO_W)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .term (tmo_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      we_reg           <= 1'b0;
      wdata_reg        <= '0;
      replay_reg       <= 1'b0;
      mem_rw_reg       <= 1'b0;
      mem_line_reg     <= '0;
      mem_response_reg <= 1'b0;
      req_valid_reg    <= 1'b0;
      req_we_reg       <= 1'b0;
      req_addr_reg     <= '0;
      req_wdata_reg    <= '0;
      resp_valid_reg   <= 1'b0;
      resp_err_reg     <= 1'b0;
      resp_data_reg    <= '0;
    end else begin
      resp_valid_reg   <= 1'b0;
      mem_response_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req_valid) begin
            addr_reg   <= cpu_req_addr;
            we_reg     <= cpu_req_we;
            wdata_reg  <= cpu_req_wdata;
            mem_rw_reg <= cpu_req_we;
            replay_reg <= 1'b0;
            state_reg  <= LOOKUP;
          end
        end
        LOOKUP: begin
          mem_rw_reg <= 1'b0;
          if (!c_miss) begin
            resp_data_reg  <= we_reg ? '0 : c_data;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else if (replay_reg) begin
            // The refilled line still misses: give up rather than loop.
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b1;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else if (c_evict) begin
            req_valid_reg <= 1'b1;
            req_we_reg    <= 1'b1;
            req_addr_reg  <= c_evict_addr;
            req_wdata_reg <= c_evict_data;
            state_reg     <= WB;
          end else begin
            req_valid_reg <= 1'b1;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= fetch_addr;
            req_wdata_reg <= '0;
            state_reg     <= FETCH;
          end
        end
        WB: begin
          if (mem_req_ready) begin
            req_we_reg    <= 1'b0;
            req_addr_reg  <= fetch_addr;
            req_wdata_reg <= '0;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          if (mem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_response_reg) begin
            mem_rw_reg <= we_reg;
            replay_reg <= 1'b1;
            state_reg  <= LOOKUP;
          end else if (mem_resp_valid) begin
            mem_line_reg     <= mem_resp_data;
            mem_response_reg <= 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      if (tmo_en && tmo_term && !mem_progress) begin
        req_valid_reg  <= 1'b0;
        req_we_reg     <= 1'b0;
        resp_data_reg  <= '0;
        resp_err_reg   <= 1'b1;
        resp_valid_reg <= 1'b1;
        state_reg      <= RESP;
      end
    end
  end

  assign cpu_req_ready  = (state_reg == IDLE) && !rst;
  assign cpu_resp_valid = resp_valid_reg;
  assign cpu_resp_data  = resp_data_reg;
  assign cpu_resp_err   = resp_err_reg;
  assign c_tag          = fields.tag;
  assign c_index        = fields.index;
  assign c_offset       = fields.offset;
  assign c_dataW        = wdata_reg;
  assign c_memRW        = mem_rw_reg;
  assign c_mem_line     = mem_line_reg;
  assign c_mem_response = mem_response_reg;
  assign mem_req_valid  = req_valid_reg;
  assign mem_req_we     = req_we_reg;
  assign mem_req_addr   = req_addr_reg;
  assign mem_req_wdata  = req_wdata_reg;

`ifdef SA_CACHE_PERF_CNT_EN
  logic [31:0] hits_reg;
  logic [31:0] misses_reg;
  logic [31:0] evicts_reg;
  logic        first_pass;

  assign first_pass = (state_reg == LOOKUP) && !replay_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_reg   <= '0;
      misses_reg <= '0;
      evicts_reg <= '0;
    end else if (first_pass) begin
      if (!c_miss && hits_reg != '1) hits_reg <= hits_reg + 1'b1;
      if (c_miss && misses_reg != '1) misses_reg <= misses_reg + 1'b1;
      if (c_miss && c_evict && evicts_reg != '1) evicts_reg <= evicts_reg + 1'b1;
    end
  end

  assign perf_hits   = hits_reg;
  assign perf_misses = misses_reg;
  assign perf_evicts = evicts_reg;
`endif

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Directed bench for sa_cache_miss_ctrl: a table of hit transactions plus
// hand-written miss, writeback, timeout, replay-abort and reset sequences.
module tb_sa_cache_miss_ctrl;

  localparam int MEM_TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_we;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_err;
  logic [17:0] c_tag;
  logic [7:0]  c_index;
  logic [5:0]  c_offset;
  logic [31:0] c_dataW;
  logic        c_memRW;
  logic [31:0] c_mem_line;
  logic        c_mem_response;
  logic [31:0] c_data;
  logic        c_miss;
  logic        c_evict;
  logic [31:0] c_evict_data;
  logic [31:0] c_evict_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef SA_CACHE_PERF_CNT_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
  logic [31:0] perf_evicts;
`endif

  sa_cache_miss_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .cpu_resp_err   (cpu_resp_err),
    .c_tag          (c_tag),
    .c_index        (c_index),
    .c_offset       (c_offset),
    .c_dataW        (c_dataW),
    .c_memRW        (c_memRW),
    .c_mem_line     (c_mem_line),
    .c_mem_response (c_mem_response),
    .c_data         (c_data),
    .c_miss         (c_miss),
    .c_evict        (c_evict),
    .c_evict_data   (c_evict_data),
    .c_evict_addr   (c_evict_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef SA_CACHE_PERF_CNT_EN
    ,
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses),
    .perf_evicts    (perf_evicts)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] cdata;
    logic [17:0] tag;
    logic [7:0]  index;
    logic [5:0]  offset;
    logic [31:0] rdata;
  } hit_vec_t;

  hit_vec_t vecs[5];
  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hit: response appears in the second cycle after the handshake cycle.
  task automatic do_hit(input hit_vec_t v);
    chk("req_ready", cpu_req_ready, 1);
    cpu_req_valid = 1; cpu_req_addr = v.addr; cpu_req_we = v.we; cpu_req_wdata = v.wdata;
    c_miss = 0; c_evict = 0; c_data = v.cdata;
    step();
    cpu_req_valid = 0;
    chk("c_tag", c_tag, v.tag);
    chk("c_index", c_index, v.index);
    chk("c_offset", c_offset, v.offset);
    chk("c_memRW", c_memRW, v.we);
    chk("c_dataW", c_dataW, v.wdata);
    chk("resp_early", cpu_resp_valid, 0);
    step();
    chk("resp_valid", cpu_resp_valid, 1);
    chk("resp_data", cpu_resp_data, v.rdata);
    chk("resp_err", cpu_resp_err, 0);
    chk("hit_no_mem", mem_req_valid, 0);
    step();
    chk("resp_pulse", cpu_resp_valid, 0);
    chk("back_idle", cpu_req_ready, 1);
  endtask

  // Miss with memory always ready; optionally the replay also misses.
  task automatic miss_txn(input logic [31:0] addr, input logic evict, input logic [31:0] refill,
                          input logic replay_miss);
    int i;
    cpu_req_valid = 1; cpu_req_addr = addr; cpu_req_we = 0;
    c_miss = 1; c_evict = evict; c_evict_addr = 32'h0002_0000; c_evict_data = 32'h0BAD_F00D;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = refill;
    step();
    cpu_req_valid = 0;
    for (i = 0; i < 20 && !c_mem_response; i++) step();
    chk("miss_refill_seen", c_mem_response, 1);
    chk("miss_refill_line", c_mem_line, refill);
    mem_resp_valid = 0; mem_req_ready = 0; c_evict = 0;
    c_miss = replay_miss; c_data = refill;
    for (i = 0; i < 10 && !cpu_resp_valid; i++) step();
    chk("miss_resp_valid", cpu_resp_valid, 1);
    chk("miss_resp_err", cpu_resp_err, replay_miss);
    chk("miss_resp_data", cpu_resp_data, replay_miss ? 32'h0 : refill);
    c_miss = 0;
    step();
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{32'h0000_4040, 1'b0, 32'h0,         32'hDEAD_BEEF, 18'h00001, 8'h01, 6'h00, 32'hDEAD_BEEF};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0102_0304, 18'h3FFFF, 8'hFF, 6'h3F, 32'h0102_0304};
    vecs[2] = '{32'h1234_5678, 1'b1, 32'hCAFE_F00D, 32'h5555_5555, 18'h048D1, 8'h59, 6'h38, 32'h0};
    vecs[3] = '{32'h0000_0000, 1'b0, 32'h0,         32'h0,         18'h00000, 8'h00, 6'h00, 32'h0};
    vecs[4] = '{32'h0000_003F, 1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 18'h00000, 8'h00, 6'h3F, 32'h0};

    rst = 1; cpu_req_valid = 0; cpu_req_addr = 0; cpu_req_we = 0; cpu_req_wdata = 0;
    c_data = 0; c_miss = 0; c_evict = 0; c_evict_data = 0; c_evict_addr = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    step();
    step();
    chk("ready_in_rst", cpu_req_ready, 0);
    rst = 0;
    #1;
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_resp", c_mem_response, 0);
    chk("rst_memRW", c_memRW, 0);
    chk("rst_tag", c_tag, 0);
    @(negedge clk);

    for (int v = 0; v < 5; v++) do_hit(vecs[v]);

    // Load miss, no evict; memory answers 3 cycles after the fetch is taken.
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_4040; cpu_req_we = 0;
    c_miss = 1; c_evict = 0;
    step();
    cpu_req_valid = 0;
    step();
    chk("f_valid", mem_req_valid, 1);
    chk("f_we", mem_req_we, 0);
    chk("f_addr", mem_req_addr, 32'h0000_4040);
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0;
    step();
    chk("f_dropped", mem_req_valid, 0);
    chk("f_same_cycle_resp", c_mem_response, 0);
    mem_req_ready = 0; mem_resp_valid = 0;
    step();
    step();
    chk("f_no_early_refill", c_mem_response, 0);
    mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    step();
    chk("f_refill_pulse", c_mem_response, 1);
    chk("f_refill_line", c_mem_line, 32'h1234_5678);
    mem_resp_valid = 0; c_miss = 0; c_data = 32'h1234_5678;
    step();
    chk("f_pulse_once", c_mem_response, 0);
    chk("f_replay_no_resp", cpu_resp_valid, 0);
    step();
    chk("f_resp_valid", cpu_resp_valid, 1);
    chk("f_resp_data", cpu_resp_data, 32'h1234_5678);
    chk("f_resp_err", cpu_resp_err, 0);
    step();

    // Store miss evicting a dirty line: writeback precedes fetch.
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_4040; cpu_req_we = 1; cpu_req_wdata = 32'h1111_2222;
    c_miss = 1; c_evict = 1; c_evict_addr = 32'h0001_0080; c_evict_data = 32'hA5A5_A5A5;
    step();
    cpu_req_valid = 0;
    step();
    c_evict_addr = 32'h0; c_evict_data = 32'h0;
    chk("wb_valid", mem_req_valid, 1);
    chk("wb_we", mem_req_we, 1);
    chk("wb_addr", mem_req_addr, 32'h0001_0080);
    chk("wb_wdata", mem_req_wdata, 32'hA5A5_A5A5);
    step();
    chk("wb_held", mem_req_valid & mem_req_we, 1);
    chk("wb_addr_held", mem_req_addr, 32'h0001_0080);
    mem_req_ready = 1;
    step();
    chk("wbf_valid", mem_req_valid, 1);
    chk("wbf_we", mem_req_we, 0);
    chk("wbf_addr", mem_req_addr, 32'h0000_4040);
    step();
    chk("wbf_done", mem_req_valid, 0);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
    step();
    chk("wb_refill", c_mem_response, 1);
    mem_resp_valid = 0; c_miss = 0; c_evict = 0; c_data = 32'h0000_0099;
    step();
    chk("wb_replay_store", c_memRW, 1);
    step();
    chk("wb_resp_valid", cpu_resp_valid, 1);
    chk("wb_resp_err", cpu_resp_err, 0);
    chk("wb_resp_data", cpu_resp_data, 0);
    step();

    // Fetch never accepted: watchdog abort.
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_8000; cpu_req_we = 0;
    c_miss = 1; c_evict = 0; mem_req_ready = 0;
    step();
    cpu_req_valid = 0;
    cyc = 0;
    while (cyc < 400 && !cpu_resp_valid) begin
      step();
      cyc++;
    end
    chk("tmo_resp_valid", cpu_resp_valid, 1);
    chk("tmo_err", cpu_resp_err, 1);
    chk("tmo_data", cpu_resp_data, 0);
    chk("tmo_mem_dropped", mem_req_valid, 0);
    chk("tmo_latency_ok", (cyc >= MEM_TIMEOUT && cyc <= MEM_TIMEOUT + 3), 1);
    c_miss = 0;
    step();
    chk("tmo_idle", cpu_req_ready, 1);

    // Replay that misses again is reported as an error.
    miss_txn(32'h0000_1000, 1'b0, 32'h3333_4444, 1'b1);

    // Reset while waiting for the refill.
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_C0C0; cpu_req_we = 0;
    c_miss = 1; c_evict = 0; mem_req_ready = 1;
    step();
    cpu_req_valid = 0;
    step();
    chk("r_fetch", mem_req_valid, 1);
    step();
    mem_req_ready = 0;
    rst = 1; mem_resp_valid = 1; mem_resp_data = 32'hEEEE_EEEE;
    #1;
    chk("r_ready_low", cpu_req_ready, 0);
    chk("r_mem_addr", mem_req_addr, 0);
    chk("r_memRW", c_memRW, 0);
    step();
    chk("r_no_resp", cpu_resp_valid, 0);
    chk("r_no_refill", c_mem_response, 0);
    rst = 0; mem_resp_valid = 0; c_miss = 0;
    #1;
    chk("r_ready_after", cpu_req_ready, 1);
    @(negedge clk);
    do_hit(vecs[0]);

`ifdef SA_CACHE_PERF_CNT_EN
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    do_hit(vecs[1]);
    do_hit(vecs[2]);
    do_hit(vecs[3]);
    miss_txn(32'h0000_2000, 1'b0, 32'h5151_5151, 1'b0);
    miss_txn(32'h0000_3000, 1'b1, 32'h6262_6262, 1'b0);
    chk("perf_hits", perf_hits, 3);
    chk("perf_misses", perf_misses, 2);
    chk("perf_evicts", perf_evicts, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
